link_output_arbiter: RTL and testbench

//  Per-output-link wormhole arbiter inside each torus node. Shares one outgoing

---
 rtl/link_output_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_link_output_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_output_arbiter.sv
// Wormhole output-link arbiter: round-robin on packet heads, packet lock until
// tail, credit-based flow control, registered link word.
module link_output_arbiter #(
    parameter int FLIT_SIZE = 82,
    parameter int NUM_IN    = 7,
    parameter int BUF_DEPTH = 8,
    parameter int CRD_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_IN*(FLIT_SIZE+1)-1:0]   req_flit,
    output logic [NUM_IN-1:0]                 gnt,
    output logic [FLIT_SIZE:0]                out_flit,
    input  logic                              credit_ret,
    output logic [CRD_W-1:0]                  credits,
    output logic                              busy,
    output logic [2:0]                        owner,
    output logic                              proto_err
);

    localparam int               FW        = FLIT_SIZE + 1;
    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_LOCKED = 1'b1;
    localparam logic [CRD_W-1:0] CRD_FULL  = CRD_W'(BUF_DEPTH);
    localparam logic [CRD_W-1:0] CRD_ONE   = CRD_W'(1);
    localparam logic [2:0]       PTR_INIT  = 3'(NUM_IN - 1);

    // Round-robin position step positions after base, modulo NUM_IN.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int step);
        return 3'((int'(base) + step) % NUM_IN);
    endfunction

    logic [0:0]       state_q,     state_d;
    logic [2:0]       rr_ptr_q,    rr_ptr_d;
    logic [2:0]       owner_q,     owner_d;
    logic             busy_q,      busy_d;
    logic             proto_err_q, proto_err_d;
    logic [CRD_W-1:0] credits_q,   credits_d;
    logic [FW-1:0]    out_flit_q,  out_flit_d;

    logic [FW-1:0]     flit_s [NUM_IN];
    logic [NUM_IN-1:0] vld_s;
    logic [NUM_IN-1:0] head_s;
    logic [NUM_IN-1:0] tail_s;
    logic [NUM_IN-1:0] cand_s;
    logic              win_found_s;
    logic [2:0]        win_idx_s;
    logic              gnt_any_s;
    logic [2:0]        gnt_idx_s;
    logic [NUM_IN-1:0] gnt_s;
    logic [FW-1:0]     sel_flit_s;
    logic              sel_head_s;
    logic              sel_tail_s;

    // Split the requester bus into per-port flits and header flags.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            flit_s[i] = req_flit[i*FW +: FW];
            vld_s[i]  = flit_s[i][FLIT_SIZE];
            head_s[i] = flit_s[i][FLIT_SIZE-1];
            tail_s[i] = flit_s[i][FLIT_SIZE-2];
            cand_s[i] = vld_s[i] & head_s[i];
        end
    end

    // First head candidate after rr_ptr in circular order.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!win_found_s && cand_s[wrap_idx(rr_ptr_q, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = wrap_idx(rr_ptr_q, k);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant selection; a locked packet only competes with itself.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 3'd0;
        if (!rst) begin
            gnt_any_s = 1'b0;
        end else if (credits_q == '0) begin
            gnt_any_s = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            gnt_any_s = vld_s[owner_q];
            gnt_idx_s = owner_q;
        end else begin
            gnt_any_s = win_found_s;
            gnt_idx_s = win_idx_s;
        end
        gnt_s      = gnt_any_s ? (NUM_IN'(1) << gnt_idx_s) : '0;
        sel_flit_s = flit_s[gnt_idx_s];
        sel_head_s = head_s[gnt_idx_s];
        sel_tail_s = tail_s[gnt_idx_s];
    end

    // Next-state: lock tracking, credit accounting and link word.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q;
        credits_d   = credits_q;
        out_flit_d  = gnt_any_s ? sel_flit_s : '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    rr_ptr_d = gnt_idx_s;
                    if (!sel_tail_s) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (gnt_any_s) begin
                    if (sel_head_s) begin
                        proto_err_d = 1'b1;
                    end else begin
                        proto_err_d = proto_err_q;
                    end
                    state_d = sel_tail_s ? ST_IDLE : ST_LOCKED;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A return at full credit without a matching grant is a downstream bug.
        case ({gnt_any_s, credit_ret})
            2'b10: begin
                credits_d = credits_q - CRD_ONE;
            end
            2'b01: begin
                if (credits_q == CRD_FULL) begin
                    proto_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CRD_ONE;
                end
            end
            default: begin
                credits_d = credits_q;
            end
        endcase

        busy_d = (state_d == ST_LOCKED);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PTR_INIT;
            owner_q     <= 3'd0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
            credits_q   <= CRD_FULL;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
            credits_q   <= credits_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign gnt       = gnt_s;
    assign out_flit  = out_flit_q;
    assign credits   = credits_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_link_output_arbiter.sv
// Directed bench for link_output_arbiter with immediate-assertion checks.
module tb_link_output_arbiter;

    localparam int FW = 83;
    localparam int N  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*FW-1:0] req_flit;
    logic [N-1:0]    gnt;
    logic [FW-1:0]   out_flit;
    logic            credit_ret;
    logic [3:0]      credits;
    logic            busy;
    logic [2:0]      owner;
    logic            proto_err;

    logic [FW-1:0]   req [N];
    int              n_chk  = 0;
    int              n_fail = 0;

    link_output_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_flit   (req_flit),
        .gnt        (gnt),
        .out_flit   (out_flit),
        .credit_ret (credit_ret),
        .credits    (credits),
        .busy       (busy),
        .owner      (owner),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_flit = '0;
        for (int i = 0; i < N; i++) req_flit[i*FW +: FW] = req[i];
    end

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [79:0] p);
        return {1'b1, h, t, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        for (int i = 0; i < N; i++) req[i] = '0;
    endtask

    initial begin
        logic [6:0] one;
        logic [FW-1:0] s;
        one = 7'd1;
        rst = 1'b0;
        credit_ret = 1'b0;
        clr_req();

        // Reset: gnt suppressed even with a valid single-flit request
        req[2] = mk(1'b1, 1'b1, 80'h5);
        #1;
        chk("rst_gnt", gnt, 7'd0);
        tick();
        tick();
        chk("rst_gnt2", gnt, 7'd0);
        chk("rst_credits", credits, 4'd8);
        chk("rst_out", out_flit, 83'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 3'd0);
        chk("rst_perr", proto_err, 1'b0);

        // 1: single-flit packet from requester 2
        rst = 1'b1;
        req[2] = mk(1'b1, 1'b1, 80'hABC);
        #1;
        chk("t1_gnt", gnt, 7'b0000100);
        tick();
        chk("t1_out", out_flit, mk(1'b1, 1'b1, 80'hABC));
        chk("t1_credits", credits, 4'd7);
        chk("t1_busy", busy, 1'b0);
        req[2] = '0;

        // Move rr_ptr to 0 with a single-flit packet from requester 0
        req[0] = mk(1'b1, 1'b1, 80'h10);
        #1;
        chk("t2_pre_gnt", gnt, 7'b0000001);
        tick();
        chk("t2_pre_credits", credits, 4'd6);

        // 2: heads on 0 and 3, rr_ptr=0 -> 3 wins, then 0 after 3's tail
        req[0] = mk(1'b1, 1'b0, 80'h20);
        req[3] = mk(1'b1, 1'b0, 80'h30);
        #1;
        chk("t2_gnt3", gnt, 7'b0001000);
        tick();
        chk("t2_out_h3", out_flit, mk(1'b1, 1'b0, 80'h30));
        chk("t2_busy", busy, 1'b1);
        chk("t2_owner3", owner, 3'd3);
        req[3] = mk(1'b0, 1'b1, 80'h31);
        #1;
        chk("t2_gnt3_tail", gnt, 7'b0001000);
        tick();
        chk("t2_out_t3", out_flit, mk(1'b0, 1'b1, 80'h31));
        chk("t2_idle", busy, 1'b0);
        req[3] = '0;
        #1;
        chk("t2_gnt0", gnt, 7'b0000001);
        tick();
        chk("t2_owner0", owner, 3'd0);
        chk("t2_busy0", busy, 1'b1);
        chk("t2_credits3", credits, 4'd3);

        // 5a: grant and credit return together at credits=3
        req[0] = mk(1'b0, 1'b1, 80'h21);
        credit_ret = 1'b1;
        #1;
        chk("t5_gnt0", gnt, 7'b0000001);
        tick();
        chk("t5_credits_hold", credits, 4'd3);
        chk("t5_idle", busy, 1'b0);
        chk("t5_perr0", proto_err, 1'b0);
        req[0] = '0;

        // Refill to 8, then a spurious return -> proto_err
        for (int i = 0; i < 5; i++) tick();
        chk("t5_refill", credits, 4'd8);
        tick();
        chk("t5_over_credits", credits, 4'd8);
        chk("t5_perr1", proto_err, 1'b1);

        // 2b: fairness with 7 saturating single-flit requesters, credits recycled
        for (int i = 0; i < N; i++) req[i] = mk(1'b1, 1'b1, 80'(i + 100));
        for (int c = 0; c < 14; c++) begin
            #1;
            chk("fair_gnt", gnt, one << ((1 + c) % N));
            tick();
            chk("fair_out", out_flit, req[(1 + c) % N]);
            chk("fair_credits", credits, 4'd8);
        end
        credit_ret = 1'b0;
        clr_req();

        // 3: 4-flit packet from req 1 blocks req 5's head
        req[1] = mk(1'b1, 1'b0, 80'h40);
        req[5] = mk(1'b1, 1'b0, 80'h50);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_gnt1", gnt, 7'b0000010);
            tick();
            chk("t3_out", out_flit, req[1]);
            chk("t3_busy", busy, (k == 3) ? 1'b0 : 1'b1);
            chk("t3_owner", owner, 3'd1);
            req[1] = mk(1'b0, (k == 2) ? 1'b1 : 1'b0, 80'(h41_val(k)));
        end
        req[1] = '0;
        #1;
        chk("t3_gnt5", gnt, 7'b0100000);
        tick();
        chk("t3_owner5", owner, 3'd5);
        chk("t3_credits", credits, 4'd3);
        req[5] = mk(1'b0, 1'b1, 80'h51);
        tick();
        chk("t3_end", busy, 1'b0);
        req[5] = '0;

        // 4: 10-flit packet with 8 credits stalls after 8 grants
        credit_ret = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        credit_ret = 1'b0;
        chk("t4_full", credits, 4'd8);
        for (int k = 0; k < 8; k++) begin
            req[4] = mk((k == 0) ? 1'b1 : 1'b0, 1'b0, 80'(k + 200));
            #1;
            chk("t4_gnt4", gnt, 7'b0010000);
            tick();
            chk("t4_credits", credits, 4'(7 - k));
        end
        req[4] = mk(1'b0, 1'b0, 80'd208);
        #1;
        chk("t4_stall_gnt", gnt, 7'd0);
        tick();
        chk("t4_stall_out", out_flit, 83'd0);
        chk("t4_lock", busy, 1'b1);
        chk("t4_owner", owner, 3'd4);
        credit_ret = 1'b1;
        #1;
        chk("t4_no_bypass", gnt, 7'd0);
        tick();
        credit_ret = 1'b0;
        chk("t4_cred1", credits, 4'd1);
        #1;
        chk("t4_one_more", gnt, 7'b0010000);
        s = req[4];
        tick();
        chk("t4_out_extra", out_flit, s);
        chk("t4_cred0", credits, 4'd0);
        chk("t4_stall_again", gnt, 7'd0);

        // 6: reset mid-packet with credits=2
        req[4] = '0;
        credit_ret = 1'b1;
        tick();
        tick();
        credit_ret = 1'b0;
        chk("t6_credits2", credits, 4'd2);
        chk("t6_locked", busy, 1'b1);
        req[4] = mk(1'b0, 1'b0, 80'd209);
        rst = 1'b0;
        #1;
        chk("t6_gnt_rst", gnt, 7'd0);
        tick();
        chk("t6_busy", busy, 1'b0);
        chk("t6_credits", credits, 4'd8);
        chk("t6_out", out_flit, 83'd0);
        chk("t6_perr", proto_err, 1'b0);
        rst = 1'b1;
        req[0] = mk(1'b1, 1'b1, 80'h60);
        req[2] = mk(1'b1, 1'b1, 80'h62);
        #1;
        chk("t6_rr_reset", gnt, 7'b0000001);
        tick();
        chk("t6_out_after", out_flit, mk(1'b1, 1'b1, 80'h60));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic int h41_val(input int k);
        return 16'h41 + k;
    endfunction

endmodule
